// File: rtl/div_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_arbiter                                                |
// | Description : Round-robin arbiter that shares one 16-bit iterative       |
// |               divider among N requesters. Operands are latched at grant, |
// |               one division is in flight at a time, and the result is     |
// |               returned with a one-cycle done pulse to the owner.         |
// | Options     : DIV_ARB_DIV0_BYPASS_EN - answer divide-by-zero locally     |
// |               without starting the divider.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module div_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      req_mode,
  input  logic [16*N-1:0]   req_num1,
  input  logic [16*N-1:0]   req_num2,
  output logic [N-1:0]      ack,
  output logic [N-1:0]      done,
  output logic [15:0]       result,
  output logic              busy,
  output logic              div_start,
  output logic              div_mode,
  output logic [15:0]       div_num1,
  output logic [15:0]       div_num2,
  input  logic              div_work,
  input  logic              div_rdy,
  input  logic [15:0]       div_result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             mode_q, mode_d;
  logic [15:0]      num1_q, num1_d;
  logic [15:0]      num2_q, num2_d;
  logic [15:0]      result_q, result_d;
  logic             first_q, first_d;
`ifdef DIV_ARB_DIV0_BYPASS_EN
  logic             byp_q, byp_d;
`endif

  logic             rr_found;
  logic [IDX_W-1:0] rr_win;
  logic [IDX_W-1:0] rr_cand;
  logic [IDX_W+3:0] rr_base;
  int               rr_j;

  // Round-robin search: first asserted request at or after the pointer, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_cand  = '0;
    rr_j     = 0;
    for (int k = 0; k < N; k++) begin
      rr_j = int'(ptr_q) + k;
      if (rr_j >= N) begin
        rr_j = rr_j - N;
      end
      rr_cand = IDX_W'(rr_j);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_win   = rr_cand;
      end
    end
    rr_base = {rr_win, 4'b0000};
  end

  // Next-state and output decode; outputs are pure functions of state except
  // div_start, which must respect the divider's current busy flag.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    mode_d    = mode_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    result_d  = result_q;
    first_d   = first_q;
`ifdef DIV_ARB_DIV0_BYPASS_EN
    byp_d     = byp_q;
`endif
    ack       = '0;
    done      = '0;
    busy      = 1'b0;
    div_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A late div_rdy here belongs to nobody and is deliberately ignored.
        if (rr_found) begin
          owner_d = rr_win;
          mode_d  = req_mode[rr_win];
          num1_d  = req_num1[rr_base +: 16];
          num2_d  = req_num2[rr_base +: 16];
          first_d = 1'b1;
`ifdef DIV_ARB_DIV0_BYPASS_EN
          byp_d   = (req_num2[rr_base +: 16] == 16'd0);
`endif
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        busy         = 1'b1;
        // Ack only on the first ISSUE cycle, even if the divider stalls us.
        ack[owner_q] = first_q;
        first_d      = 1'b0;
`ifdef DIV_ARB_DIV0_BYPASS_EN
        if (byp_q) begin
          result_d = mode_q ? num1_q : 16'hFFFF;
          state_d  = S_DONE;
        end else if (!div_work) begin
          div_start = 1'b1;
          state_d   = S_WAIT;
        end
`else
        if (!div_work) begin
          div_start = 1'b1;
          state_d   = S_WAIT;
        end
`endif
      end

      S_WAIT: begin
        busy = 1'b1;
        if (div_rdy) begin
          result_d = div_result;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        busy          = 1'b1;
        done[owner_q] = 1'b1;
        ptr_d         = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + 1'b1;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so an in-flight op is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      mode_q   <= 1'b0;
      num1_q   <= 16'd0;
      num2_q   <= 16'd0;
      result_q <= 16'd0;
      first_q  <= 1'b0;
`ifdef DIV_ARB_DIV0_BYPASS_EN
      byp_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      mode_q   <= mode_d;
      num1_q   <= num1_d;
      num2_q   <= num2_d;
      result_q <= result_d;
      first_q  <= first_d;
`ifdef DIV_ARB_DIV0_BYPASS_EN
      byp_q    <= byp_d;
`endif
    end
  end

  assign result   = result_q;
  assign div_mode = mode_q;
  assign div_num1 = num1_q;
  assign div_num2 = num2_q;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_div_arbiter                                             |
// | Description : Randomized scoreboard bench for div_arbiter with a         |
// |               behavioural divider and round-robin reference model.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_div_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_mode = '0;
  logic [16*N-1:0] req_num1 = '0;
  logic [16*N-1:0] req_num2 = '0;
  logic [N-1:0]    ack;
  logic [N-1:0]    done;
  logic [15:0]     result;
  logic            busy;
  logic            div_start;
  logic            div_mode;
  logic [15:0]     div_num1;
  logic [15:0]     div_num2;
  logic            div_work = 1'b0;
  logic            div_rdy = 1'b0;
  logic [15:0]     div_result = 16'd0;

  always #5 clk = ~clk;

  div_arbiter #(.N(N), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode),
    .req_num1(req_num1), .req_num2(req_num2), .ack(ack), .done(done),
    .result(result), .busy(busy), .div_start(div_start), .div_mode(div_mode),
    .div_num1(div_num1), .div_num2(div_num2), .div_work(div_work),
    .div_rdy(div_rdy), .div_result(div_result)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          owner;
    logic [15:0] res;
    int          starts;
  } exp_t;
  exp_t sb_q[$];
  int   ack_log[$];

  // Shared state between processes
  logic [N-1:0] ack_s = '0;
  logic [15:0]  last_res = 16'd0;
  int           done_cnt = 0;
  logic [N-1:0] hold_mask = '0;
  bit           rand_en = 1'b0;
  int           hog_force = 0;

  function automatic logic [15:0] ref_div(input logic m, input logic [15:0] a, input logic [15:0] b);
    if (b == 16'd0) return m ? a : 16'hFFFF;
    return m ? (a % b) : (a / b);
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural divider: random latency, occasional external busy periods.
  int          dv_bc = 0;
  int          dv_hc = 0;
  logic [15:0] dv_pend = 16'd0;
  logic        st_s = 1'b0, m_s = 1'b0, rst_s = 1'b1;
  logic [15:0] a_s = 16'd0, b_s = 16'd0;
  initial begin
    forever begin
      @(negedge clk);
      st_s = div_start; m_s = div_mode; a_s = div_num1; b_s = div_num2; rst_s = rst;
      @(posedge clk); #1;
      div_rdy = 1'b0;
      if (rst_s) begin
        dv_bc = 0; dv_hc = 0; div_work = 1'b0;
      end else begin
        if (st_s) begin
          dv_bc   = $urandom_range(1, 4);
          dv_pend = ref_div(m_s, a_s, b_s);
        end else if (dv_bc > 0) begin
          dv_bc--;
          if (dv_bc == 0) begin
            div_rdy    = 1'b1;
            div_result = dv_pend;
          end
        end else if (dv_hc > 0) begin
          dv_hc--;
        end else if (hog_force > 0) begin
          dv_hc = hog_force;
          hog_force = 0;
        end else if (rand_en && $urandom_range(0, 15) == 0) begin
          dv_hc = $urandom_range(1, 3);
        end
        div_work = (dv_bc > 0) || (dv_hc > 0);
      end
    end
  end

  // Monitor / scoreboard with round-robin reference model.
  logic [N-1:0] req_prev = '0;
  int           tb_ptr = 0;
  bit           inflight = 1'b0;
  int           start_cnt = 0;
  int           w, c, idx, exp_st;
  exp_t         e;
  initial begin
    forever begin
      @(negedge clk);
      ack_s = ack;
      if (rst) begin
        inflight = 1'b0; tb_ptr = 0; sb_q.delete(); req_prev = req;
        continue;
      end
      chk("ack_onehot", 32'($onehot0(ack)), 32'd1);
      chk("done_onehot", 32'($onehot0(done)), 32'd1);
      chk("busy", 32'(busy), 32'(inflight || (ack != '0)));
      if (ack != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          c = (tb_ptr + k) % N;
          if (w < 0 && req_prev[c]) w = c;
        end
        idx = idx_of(ack);
        chk("ack_while_inflight", 32'(inflight), 32'd0);
        chk("ack_owner", idx, w);
        ack_log.push_back(idx);
`ifdef DIV_ARB_DIV0_BYPASS_EN
        exp_st = (req_num2[16*idx +: 16] == 16'd0) ? 0 : 1;
`else
        exp_st = 1;
`endif
        e.owner  = idx;
        e.res    = ref_div(req_mode[idx], req_num1[16*idx +: 16], req_num2[16*idx +: 16]);
        e.starts = exp_st;
        sb_q.push_back(e);
        inflight  = 1'b1;
        start_cnt = 0;
        tb_ptr    = (idx + 1) % N;
      end
      if (div_start) begin
        chk("start_while_work", 32'(div_work), 32'd0);
        start_cnt++;
      end
      if (done != '0) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done_unexpected: got done=%b, required no done", done);
        end else begin
          e = sb_q.pop_front();
          chk("done_owner", idx_of(done), e.owner);
          chk("result", 32'(result), 32'(e.res));
          chk("start_count", start_cnt, e.starts);
        end
        last_res = result;
        done_cnt++;
        inflight = 1'b0;
      end
      req_prev = req;
    end
  end

  // One cycle of requester activity: drop acked requests, optionally raise new ones.
  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (ack_s[i] && !hold_mask[i]) begin
        req[i] = 1'b0;
        req_num1[16*i +: 16] = 16'($urandom);
        req_num2[16*i +: 16] = 16'($urandom);
        req_mode[i] = 1'($urandom);
      end else if (rand_en && !req[i] && $urandom_range(0, 3) == 0) begin
        req_mode[i] = 1'($urandom);
        req_num1[16*i +: 16] = 16'($urandom);
        if ($urandom_range(0, 5) == 0) req_num2[16*i +: 16] = 16'd0;
        else if ($urandom_range(0, 1) == 0) req_num2[16*i +: 16] = 16'($urandom_range(1, 20));
        else req_num2[16*i +: 16] = 16'($urandom);
        req[i] = 1'b1;
      end
    end
  endtask

  task automatic run_one(input string nm, input int i, input logic m,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_res);
    int d0;
    int k;
    d0 = done_cnt;
    req_mode[i] = m;
    req_num1[16*i +: 16] = a;
    req_num2[16*i +: 16] = b;
    req[i] = 1'b1;
    for (k = 0; k < 60 && done_cnt == d0; k++) step();
    if (done_cnt == d0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: no done within 60 cycles, required one", nm);
    end else begin
      chk(nm, 32'(last_res), 32'(exp_res));
      chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic wait_quiet(input string nm, input int maxc);
    int k;
    for (k = 0; k < maxc; k++) begin
      if (req == '0 && sb_q.size() == 0 && !busy) break;
      step();
    end
    n_cmp++;
    if (k == maxc) begin
      n_err++;
      $display("FAIL %s: still active after %0d cycles, required idle", nm, maxc);
    end
  endtask

  int order_exp[5];
  int d0, k;
  initial begin
    order_exp[0] = 0; order_exp[1] = 1; order_exp[2] = 2; order_exp[3] = 3; order_exp[4] = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'({ack, done, busy, div_start, div_mode}), 32'd0);
    chk("reset_data", {result, div_num1}, 32'd0);
    chk("reset_num2", 32'(div_num2), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // All four held from pointer 0: grants must rotate 0,1,2,3,0.
    ack_log.delete();
    hold_mask = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_mode[i] = 1'b0;
      req_num1[16*i +: 16] = 16'(50 + 10 * i);
      req_num2[16*i +: 16] = 16'(3 + i);
    end
    req = 4'b1111;
    for (k = 0; k < 200 && ack_log.size() < 5; k++) step();
    req = '0;
    hold_mask = '0;
    wait_quiet("rr_drain", 100);
    if (ack_log.size() < 5) begin
      n_cmp++; n_err++;
      $display("FAIL rr_order: only %0d grants, required 5", ack_log.size());
    end else begin
      for (int i = 0; i < 5; i++) chk("rr_order", ack_log[i], order_exp[i]);
    end

    run_one("quot_100_7", 0, 1'b0, 16'd100, 16'd7, 16'd14);
    run_one("rem_100_7", 0, 1'b1, 16'd100, 16'd7, 16'd2);
    run_one("div0_quot", 2, 1'b0, 16'd5, 16'd0, 16'hFFFF);
    run_one("div0_rem", 2, 1'b1, 16'd5, 16'd0, 16'd5);

    // Divider externally busy when the grant is issued.
    hog_force = 3;
    for (k = 0; k < 10 && !div_work; k++) step();
    chk("hog_active", 32'(div_work), 32'd1);
    run_one("hog_grant", 1, 1'b0, 16'd60, 16'd4, 16'd15);

    // Reset while the divider is working on a request.
    req_mode[1] = 1'b0; req_num1[31:16] = 16'd100; req_num2[31:16] = 16'd7;
    req[1] = 1'b1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy && div_work && ack == '0 && done == '0) break;
    end
    #2;
    rst = 1'b1;
    req = '0;
    @(negedge clk); #1;
    chk("midop_rst_ctrl", 32'({ack, done, busy, div_start, div_mode}), 32'd0);
    chk("midop_rst_data", {result, div_num1}, 32'd0);
    step(); step();
    rst = 1'b0;
    d0 = done_cnt;
    repeat (10) step();
    chk("no_done_after_rst", done_cnt - d0, 0);
    run_one("after_rst_9_3", 3, 1'b0, 16'd9, 16'd3, 16'd3);

    // Randomized traffic.
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    wait_quiet("final_drain", 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
